// File: rtl/div_arbiter.sv
// Round-robin front end that shares one iterative divider among NREQ requesters.
// Divide-by-zero is answered locally; a stalled divider is cut off after TMO wait cycles.
//
// state | meaning
// IDLE  | no division outstanding, arbitrating rq_valid
// ISSUE | div_req pulse visible, timeout counter cleared
// WAIT  | waiting for div_ready or timeout
// RESP  | result captured, rsp_valid goes out on exit
module div_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int TMO  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   rq_valid,
  input  logic [NREQ*N-1:0] rq_dividend,
  input  logic [NREQ*N-1:0] rq_divisor,
  output logic [NREQ-1:0]   rq_accept,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_q,
  output logic [N-1:0]      rsp_r,
  output logic              rsp_exc,
  output logic              rsp_tmo,
  output logic              div_req,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  input  logic              div_ready,
  input  logic [N-1:0]      div_q,
  input  logic [N-1:0]      div_r,
  input  logic              div_exc,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
  localparam logic [CW-1:0] CMAX = CW'(TMO - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] cnt;
  logic [PW-1:0] gnt;
  logic          found;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;

  // first set rq_valid bit at or after ptr, wrapping around
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rq_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gnt   = PW'((int'(ptr) + k) % NREQ);
      end
    end
    op_a = rq_dividend[int'(gnt)*N +: N];
    op_b = rq_divisor[int'(gnt)*N +: N];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      rq_accept    <= '0;
      rsp_valid    <= '0;
      div_req      <= 1'b0;
      busy         <= 1'b0;
      rsp_q        <= '0;
      rsp_r        <= '0;
      rsp_exc      <= 1'b0;
      rsp_tmo      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      rq_accept <= '0;
      rsp_valid <= '0;
      div_req   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            rq_accept    <= ONE << gnt;
            owner        <= gnt;
            ptr          <= (gnt == LAST) ? '0 : gnt + 1'b1;
            div_dividend <= op_a;
            div_divisor  <= op_b;
            busy         <= 1'b1;
            if (op_b == '0) begin
              state   <= RESP;
              rsp_q   <= '1;
              rsp_r   <= op_a;
              rsp_exc <= 1'b1;
              rsp_tmo <= 1'b0;
            end else begin
              state   <= ISSUE;
              div_req <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != CMAX) cnt <= cnt + 1'b1;
          // a result arriving on the last allowed cycle beats the timeout
          if (div_ready) begin
            state   <= RESP;
            rsp_q   <= div_q;
            rsp_r   <= div_r;
            rsp_exc <= div_exc;
            rsp_tmo <= 1'b0;
          end else if (cnt == CMAX) begin
            state   <= RESP;
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_exc <= 1'b1;
            rsp_tmo <= 1'b1;
          end
        end
        default: begin
          rsp_valid <= ONE << owner;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
